// File: rtl/frame_controller_pkg.sv
// frame_controller_pkg: shared state encodings and widths for the frame controller
package frame_controller_pkg;
  typedef enum logic [1:0] {ST_HUNT = 2'd0, ST_COLLECT = 2'd1, ST_LOST = 2'd2} state_t;
  localparam int WORD_W = 16;
  localparam int CNT_W = 16;
endpackage

// File: rtl/frame_controller_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered pointers and simultaneous push/pop when full
module sync_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 8
) (
  input  logic             cClk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] rdData,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wrPtr, rdPtr;
  logic doPush, doPop;
  assign empty = wrPtr == rdPtr;
  assign full = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop = pop & !empty;
  assign doPush = push & (!full | doPop);
  assign rdData = mem[rdPtr[AW-1:0]];
  // pointer update; the extra MSB distinguishes full from empty
  always_ff @(posedge cClk) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop) rdPtr <= rdPtr + 1'b1;
    end
  end
  // storage write, no reset needed since pointers gate visibility
  always_ff @(posedge cClk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= wrData;
  end
endmodule

// File: rtl/frame_controller.sv
// frame_controller: frame-level sequencing of receiver words into an indexed output FIFO
module frame_controller
  import frame_controller_pkg::*;
#(
  parameter int WORDS_PER_FRAME = 32,
  parameter int IDX_W = 5,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic              cClk,
  input  logic              reset,
  input  logic              sync,
  input  logic [WORD_W-1:0] word_in,
  input  logic              ready_in,
  output logic [WORD_W-1:0] out_word,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_valid,
  input  logic              out_ack,
  output logic              frame_done,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              overflow,
  output logic              link_lost
);
  localparam logic [IDX_W:0] WPF = WORDS_PER_FRAME[IDX_W:0];
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  state_t state, stateNext;
  logic [2:0] syncSr;
  logic readyR, readyQ, syncFront, wordRise;
  logic [WORD_W-1:0] wordR;
  logic [IDX_W:0] idx, idxNext, idxCount;
  logic excess, excessNext, excessCount, countOk;
  logic [15:0] tmo;
  logic push, doneNext, errNext, full, empty;
  logic [IDX_W+WORD_W-1:0] rdData;
  assign syncFront = syncSr[1] & !syncSr[2];
  assign wordRise = readyR & !readyQ;
  assign countOk = wordRise & (idx < WPF);
  assign idxCount = idx + {{IDX_W{1'b0}}, countOk};
  assign excessCount = excess | (wordRise & !countOk);
  assign out_valid = !empty;
  assign out_word = out_valid ? rdData[WORD_W-1:0] : '0;
  assign out_index = out_valid ? rdData[IDX_W+WORD_W-1:WORD_W] : '0;
  assign link_lost = state == ST_LOST;
  // input capture: sync shifter and one-cycle registered receiver word/ready
  always_ff @(posedge cClk) begin
    if (!reset) begin
      syncSr <= '0;
      readyR <= 1'b0;
      readyQ <= 1'b0;
      wordR <= '0;
    end else begin
      syncSr <= {syncSr[1:0], sync};
      readyR <= ready_in;
      readyQ <= readyR;
      wordR <= word_in;
    end
  end
  // FSM state register with frame index and excess flag
  always_ff @(posedge cClk) begin
    if (!reset) begin
      state <= ST_HUNT;
      idx <= '0;
      excess <= 1'b0;
    end else begin
      state <= stateNext;
      idx <= idxNext;
      excess <= excessNext;
    end
  end
  // next state: a word coinciding with a sync is counted into the closing frame
  always_comb begin
    stateNext = state;
    idxNext = idx;
    excessNext = excess;
    push = 1'b0;
    doneNext = 1'b0;
    errNext = 1'b0;
    if (state == ST_COLLECT) begin
      push = countOk;
      idxNext = idxCount;
      excessNext = excessCount;
      if (syncFront) begin
        doneNext = (idxCount == WPF) && !excessCount;
        errNext = !doneNext;
        idxNext = '0;
        excessNext = 1'b0;
      end else if (tmo == TMO_LAST && !wordRise) begin
        stateNext = ST_LOST;
        idxNext = '0;
        excessNext = 1'b0;
      end
    end else if (syncFront) begin
      stateNext = ST_COLLECT;
      idxNext = '0;
      excessNext = 1'b0;
    end
  end
  // link watchdog: cycles in COLLECT since the last word or sync
  always_ff @(posedge cClk) begin
    if (!reset || state != ST_COLLECT || wordRise || syncFront) tmo <= '0;
    else tmo <= tmo + 1'b1;
  end
  // frame status pulses, good-frame counter and sticky overflow
  always_ff @(posedge cClk) begin
    if (!reset) begin
      frame_done <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      frame_done <= doneNext;
      frame_err <= errNext;
      frame_cnt <= frame_cnt + CNT_W'(doneNext);
      overflow <= overflow | (push & full & !(out_ack & !empty));
    end
  end
  sync_fifo #(.WIDTH(IDX_W + WORD_W), .DEPTH(FIFO_DEPTH)) fifo (
    .cClk(cClk),
    .reset(reset),
    .push(push),
    .pop(out_ack),
    .wrData({idx[IDX_W-1:0], wordR}),
    .rdData(rdData),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_frame_controller.sv
// tb_frame_controller: table-driven frame checks plus hand-written overflow, timeout and reset sequences
module tb_frame_controller;
  localparam int TMO = 65535;
  logic cClk = 0, reset = 0, sync = 0, ready_in = 0, out_ack = 0;
  logic [15:0] word_in = '0;
  logic [15:0] out_word, frame_cnt;
  logic [4:0] out_index;
  logic out_valid, frame_done, frame_err, overflow, link_lost;
  int tests = 0, fails = 0, expCnt = 0;
  int doneTot = 0, errTot = 0, popN = 0;
  logic [20:0] popLog [0:1023];
  typedef struct {
    int nWords;
    int nDeliv;
    int expDone;
    int expErr;
  } vec_t;
  vec_t vecs [5];

  frame_controller #(.WORDS_PER_FRAME(32), .IDX_W(5), .FIFO_DEPTH(8), .TIMEOUT(TMO)) dut (
    .cClk(cClk), .reset(reset), .sync(sync), .word_in(word_in), .ready_in(ready_in),
    .out_word(out_word), .out_index(out_index), .out_valid(out_valid), .out_ack(out_ack),
    .frame_done(frame_done), .frame_err(frame_err), .frame_cnt(frame_cnt),
    .overflow(overflow), .link_lost(link_lost)
  );

  always #5 cClk = ~cClk;

  // monitor: count pulses and log every word the bench pops
  always @(negedge cClk) begin
    if (frame_done) doneTot++;
    if (frame_err) errTot++;
    if (out_valid && out_ack && popN < 1024) begin
      popLog[popN] = {out_index, out_word};
      popN++;
    end
  end

  task automatic tick();
    @(posedge cClk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sendWord(input logic [15:0] d);
    word_in = d;
    ready_in = 1;
    tick();
    tick();
    ready_in = 0;
    tick();
    tick();
  endtask

  task automatic sendSync();
    sync = 1;
    tick();
    tick();
    sync = 0;
    tick();
    tick();
  endtask

  task automatic checkSeq(input string name, input int base, input int n, input logic [7:0] tag);
    int bad = 0;
    for (int k = 0; k < n && base + k < popN; k++) begin
      logic [7:0] kb;
      kb = 8'(k);
      if (popLog[base + k] !== {kb[4:0], tag, kb}) bad++;
    end
    check(name, bad, 0);
  endtask

  task automatic runFrame(input string name, input logic [7:0] tag, input int n, input int nDeliv,
                          input int expDone, input int expErr);
    int bp, bd, be;
    bp = popN;
    bd = doneTot;
    be = errTot;
    for (int k = 0; k < n; k++) sendWord({tag, 8'(k)});
    sendSync();
    repeat (4) tick();
    expCnt += expDone;
    check({name, " delivered"}, popN - bp, nDeliv);
    check({name, " done"}, doneTot - bd, expDone);
    check({name, " err"}, errTot - be, expErr);
    check({name, " frame_cnt"}, frame_cnt, expCnt);
    checkSeq({name, " seq"}, bp, nDeliv, tag);
  endtask

  initial begin
    int bp, bd, be;
    vecs[0] = '{32, 32, 1, 0};
    vecs[1] = '{31, 31, 0, 1};
    vecs[2] = '{33, 32, 0, 1};
    vecs[3] = '{32, 32, 1, 0};
    vecs[4] = '{0, 0, 0, 1};
    repeat (3) tick();
    check("reset outputs", {out_word, out_index, out_valid, frame_done, frame_err, frame_cnt, overflow, link_lost}, 0);
    reset = 1;
    out_ack = 1;
    tick();
    bp = popN;
    sendWord(16'h1234);
    repeat (3) tick();
    check("hunt ignores word", popN - bp, 0);
    bd = doneTot;
    be = errTot;
    sendSync();
    repeat (2) tick();
    check("opening sync no pulse", (doneTot - bd) + (errTot - be), 0);
    for (int r = 0; r < 5; r++)
      runFrame($sformatf("row%0d", r), 8'(r + 1), vecs[r].nWords, vecs[r].nDeliv, vecs[r].expDone, vecs[r].expErr);
    check("no overflow yet", overflow, 0);
    out_ack = 0;
    bp = popN;
    for (int k = 0; k < 10; k++) sendWord({8'hB0, 8'(k)});
    check("ovf valid", out_valid, 1);
    check("ovf sticky", overflow, 1);
    out_ack = 1;
    repeat (12) tick();
    check("drain count", popN - bp, 8);
    checkSeq("drain seq", bp, 8, 8'hB0);
    check("drain empty", out_valid, 0);
    be = errTot;
    sendSync();
    repeat (2) tick();
    check("ten word frame err", errTot - be, 1);
    sendWord(16'h0001);
    sendWord(16'h0002);
    bd = doneTot;
    be = errTot;
    repeat (TMO - 20) tick();
    check("not yet lost", link_lost, 0);
    repeat (40) tick();
    check("link lost", link_lost, 1);
    check("no pulse on timeout", (doneTot - bd) + (errTot - be), 0);
    bp = popN;
    sendWord(16'h5555);
    repeat (3) tick();
    check("lost ignores word", popN - bp, 0);
    sendSync();
    check("link restored", link_lost, 0);
    runFrame("after lost", 8'hC0, 32, 32, 1, 0);
    bp = popN;
    bd = doneTot;
    be = errTot;
    for (int k = 0; k < 31; k++) sendWord({8'hD0, 8'(k)});
    word_in = {8'hD0, 8'd31};
    sync = 1;
    tick();
    ready_in = 1;
    tick();
    sync = 0;
    tick();
    ready_in = 0;
    repeat (5) tick();
    expCnt++;
    check("coincident done", doneTot - bd, 1);
    check("coincident err", errTot - be, 0);
    check("coincident frame_cnt", frame_cnt, expCnt);
    check("coincident delivered", popN - bp, 32);
    checkSeq("coincident seq", bp, 32, 8'hD0);
    sendWord(16'hE000);
    repeat (2) tick();
    check("new frame idx0", popLog[popN - 1], {5'd0, 16'hE000});
    out_ack = 0;
    overflow_set: for (int k = 0; k < 9; k++) sendWord({8'hF0, 8'(k)});
    check("pre-reset valid", out_valid, 1);
    check("pre-reset overflow", overflow, 1);
    reset = 0;
    tick();
    check("mid reset outputs", {out_word, out_index, out_valid, frame_done, frame_err, frame_cnt, overflow, link_lost}, 0);
    reset = 1;
    tick();
    sendWord(16'h7777);
    repeat (2) tick();
    check("post reset hunt", out_valid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
